fpu_sequencer: RTL and testbench



---
 rtl/fpu_pkg.sv | 19 +
 rtl/fpu_sequencer_if.sv | 27 ++
 rtl/fpu_lat_counter.sv | 20 ++
 rtl/fpu_sequencer.sv | 79 +++++++
 tb/tb_fpu_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: FPU op/state encodings, default core latencies and the op-to-latency lookup
package fpu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_ABS = 4'd4,
    OP_NEG = 4'd5
  } fpu_op_t;
  typedef enum logic [1:0] {IDLE, EXEC, WB} fpu_state_t;
  localparam int LAT_ADD_DEF = 2;
  localparam int LAT_MUL_DEF = 4;
  localparam int LAT_DIV_DEF = 16;
  localparam int LAT_SGN_DEF = 1;
  function automatic int lat_of(fpu_op_t op, int la, int lm, int ld, int ls);
    return (op == OP_MUL) ? lm : (op == OP_DIV) ? ld : (op == OP_ABS || op == OP_NEG) ? ls : la;
  endfunction
endpackage

// File: rtl/fpu_sequencer_if.sv
// fpu_sequencer_if: decoder inputs, FPU core handshake and FP write-back bundle (slave = sequencer, master = CPU/core side)
interface fpu_sequencer_if;
  logic [3:0]  fpu_control;
  logic        fp_regwrite;
  logic        mem_to_fp;
  logic [4:0]  fd;
  logic [31:0] fs_data;
  logic [31:0] ft_data;
  logic [3:0]  core_op;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_start;
  logic [31:0] core_result;
  logic        stall;
  logic        fp_we;
  logic [4:0]  fp_waddr;
  logic [31:0] fp_wdata;
  logic        fpu_illegal;
  modport slave (
    input  fpu_control, fp_regwrite, mem_to_fp, fd, fs_data, ft_data, core_result,
    output core_op, core_a, core_b, core_start, stall, fp_we, fp_waddr, fp_wdata, fpu_illegal
  );
  modport master (
    output fpu_control, fp_regwrite, mem_to_fp, fd, fs_data, ft_data, core_result,
    input  core_op, core_a, core_b, core_start, stall, fp_we, fp_waddr, fp_wdata, fpu_illegal
  );
endinterface

// File: rtl/fpu_lat_counter.sv
// fpu_lat_counter: loadable saturating down-counter with zero flag (clk, reset, load, load_val, dec -> cnt, zero)
module fpu_lat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt  = cnt_q;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: IDLE/EXEC/WB sequencer driving a fixed-latency FPU core, stalling the CPU and writing the result back (clk, reset, io)
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int LAT_SGN = LAT_SGN_DEF
) (
  input logic             clk,
  input logic             reset,
  fpu_sequencer_if.slave  io
);
  localparam int LMAX_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LMAX_DS = (LAT_DIV > LAT_SGN) ? LAT_DIV : LAT_SGN;
  localparam int LMAX    = (LMAX_AM > LMAX_DS) ? LMAX_AM : LMAX_DS;
  localparam int CW      = $clog2(LMAX) + 1;
  fpu_state_t  state_q, state_d;
  fpu_op_t     op_q, op_d;
  logic [4:0]  fd_q, fd_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        start_q, start_d, ill_q, ill_d;
  logic        issue, legal, go, done;
  logic [CW-1:0] cnt, cnt_load;
  logic        cnt_zero;
  always_comb begin
    issue    = io.fp_regwrite & ~io.mem_to_fp & (state_q == IDLE);
    legal    = io.fpu_control <= 4'd5;
    go       = issue & legal;
    done     = (state_q == EXEC) & cnt_zero;
    cnt_load = CW'(lat_of(fpu_op_t'(io.fpu_control), LAT_ADD, LAT_MUL, LAT_DIV, LAT_SGN) - 1);
    op_d     = go ? fpu_op_t'(io.fpu_control) : op_q;
    fd_d     = go ? io.fd : fd_q;
    a_d      = go ? io.fs_data : a_q;
    b_d      = go ? io.ft_data : b_q;
    res_d    = done ? io.core_result : res_q;
    start_d  = go;
    ill_d    = issue & ~legal;
    state_d  = go ? EXEC : done ? WB : (state_q == WB) ? IDLE : state_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      fd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fd_q    <= fd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      start_q <= start_d;
      ill_q   <= ill_d;
    end
  fpu_lat_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (go),
    .load_val (cnt_load),
    .dec      (state_q == EXEC),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );
  assign io.core_op     = op_q;
  assign io.core_a      = a_q;
  assign io.core_b      = b_q;
  assign io.core_start  = start_q;
  assign io.stall       = go | (state_q == EXEC);
  assign io.fp_we       = state_q == WB;
  assign io.fp_waddr    = fd_q;
  assign io.fp_wdata    = res_q;
  assign io.fpu_illegal = ill_q;
endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: directed vectors with a write-back scoreboard and a behavioural fixed-latency core model
module tb_fpu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  logic [36:0] exp_q[$];
  fpu_sequencer_if io();
  fpu_sequencer dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  function automatic int core_lat(logic [3:0] op);
    return (op == 4'd2) ? 4 : (op == 4'd3) ? 16 : (op == 4'd4 || op == 4'd5) ? 1 : 2;
  endfunction
  function automatic logic [31:0] core_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0: return (a == 32'h3FC00000 && b == 32'h40100000) ? 32'h40700000 : 32'hDEADBEEF;
      4'd2: return (a == 32'h40000000 && b == 32'h40400000) ? 32'h40C00000 : 32'hDEADBEEF;
      4'd3: return (a == 32'h41200000 && b == 32'h40000000) ? 32'h40A00000 : 32'hDEADBEEF;
      4'd4: return {1'b0, a[30:0]};
      4'd5: return {~a[31], a[30:0]};
      default: return 32'hDEADBEEF;
    endcase
  endfunction
  always @(posedge clk)
    if (io.core_start) ecnt <= 2;
    else if (ecnt != 0 && ecnt < 1000) ecnt <= ecnt + 1;
  always_comb begin
    io.core_result = 32'hDEADBEEF;
    if ((io.core_start ? 1 : ecnt) == core_lat(io.core_op))
      io.core_result = core_fn(io.core_op, io.core_a, io.core_b);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk)
    if (io.fp_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got write f%0d=%h expected no write", io.fp_waddr, io.fp_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({io.fp_waddr, io.fp_wdata} !== e) begin
          errors++;
          $display("FAIL wb_data: got f%0d=%h expected f%0d=%h", io.fp_waddr, io.fp_wdata, e[36:32], e[31:0]);
        end
      end
    end
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      io.fp_regwrite = 1'b0;
      io.mem_to_fp = 1'b0;
      @(negedge clk);
      chk("idle_stall", 32'(io.stall), 32'd0);
    end
  endtask
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp, input int lat, input bit tog);
    @(posedge clk);
    #1;
    io.fp_regwrite = 1'b1;
    io.mem_to_fp = 1'b0;
    io.fpu_control = op;
    io.fd = d;
    io.fs_data = a;
    io.ft_data = b;
    exp_q.push_back({d, exp});
    @(negedge clk);
    chk("issue_stall", 32'(io.stall), 32'd1);
    chk("issue_start", 32'(io.core_start), 32'd0);
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      if (tog) begin
        io.fs_data = ~io.fs_data;
        io.ft_data = io.ft_data ^ 32'h00001234;
        io.fd = io.fd ^ 5'h1f;
        io.fpu_control = 4'd1;
      end
      @(negedge clk);
      chk("exec_stall", 32'(io.stall), 32'(c <= lat));
      chk("exec_we", 32'(io.fp_we), 32'(c == lat + 1));
      if (c <= lat) chk("exec_start", 32'(io.core_start), 32'(c == 1));
    end
  endtask
  initial begin
    io.fpu_control = 4'd0;
    io.fp_regwrite = 1'b0;
    io.mem_to_fp = 1'b0;
    io.fd = 5'd0;
    io.fs_data = 32'd0;
    io.ft_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(io.stall), 32'd0);
    chk("rst_we", 32'(io.fp_we), 32'd0);
    chk("rst_illegal", 32'(io.fpu_illegal), 32'd0);
    chk("rst_start", 32'(io.core_start), 32'd0);
    chk("rst_core_a", io.core_a, 32'd0);
    chk("rst_core_b", io.core_b, 32'd0);
    chk("rst_core_op", 32'(io.core_op), 32'd0);
    chk("rst_waddr", 32'(io.fp_waddr), 32'd0);
    chk("rst_wdata", io.fp_wdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    run_op(4'd0, 32'h3FC00000, 32'h40100000, 5'd3, 32'h40700000, 2, 1'b0);
    idle(2);
    run_op(4'd3, 32'h41200000, 32'h40000000, 5'd7, 32'h40A00000, 16, 1'b0);
    idle(2);
    run_op(4'd5, 32'h3F800000, 32'h00000000, 5'd1, 32'hBF800000, 1, 1'b0);
    run_op(4'd4, 32'hC0000000, 32'h00000000, 5'd2, 32'h40000000, 1, 1'b0);
    idle(2);
    @(posedge clk);
    #1;
    io.fp_regwrite = 1'b1;
    io.fpu_control = 4'b0111;
    @(negedge clk);
    chk("ill_stall", 32'(io.stall), 32'd0);
    chk("ill_pulse_pre", 32'(io.fpu_illegal), 32'd0);
    @(posedge clk);
    #1;
    io.fp_regwrite = 1'b0;
    @(negedge clk);
    chk("ill_pulse", 32'(io.fpu_illegal), 32'd1);
    chk("ill_we", 32'(io.fp_we), 32'd0);
    @(negedge clk);
    chk("ill_pulse_once", 32'(io.fpu_illegal), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      io.fp_regwrite = 1'b1;
      io.mem_to_fp = 1'b1;
      io.fpu_control = 4'd0;
      @(negedge clk);
      chk("load_stall", 32'(io.stall), 32'd0);
      chk("load_we", 32'(io.fp_we), 32'd0);
    end
    idle(2);
    run_op(4'd2, 32'h40000000, 32'h40400000, 5'd9, 32'h40C00000, 4, 1'b1);
    idle(2);
    @(posedge clk);
    #1;
    io.fp_regwrite = 1'b1;
    io.fpu_control = 4'd3;
    io.fd = 5'd12;
    io.fs_data = 32'h41200000;
    io.ft_data = 32'h40000000;
    @(negedge clk);
    chk("rdiv_issue_stall", 32'(io.stall), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) reset = 1'b1;
      @(negedge clk);
      chk("rdiv_exec_stall", 32'(io.stall), 32'd1);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    io.fp_regwrite = 1'b0;
    @(negedge clk);
    chk("rdiv_abort_stall", 32'(io.stall), 32'd0);
    chk("rdiv_abort_start", 32'(io.core_start), 32'd0);
    chk("rdiv_abort_wdata", io.fp_wdata, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rdiv_no_we", 32'(io.fp_we), 32'd0);
      chk("rdiv_no_stall", 32'(io.stall), 32'd0);
    end
    idle(2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
